timer_cnt_ctrl: RTL and testbench
=================================

# timer_cnt_ctrl

Count-enable controller for the APB timer: owns the prescale configuration shadow, generates the single-cycle `tick` that advances the timer counter, and sequences run, halt and idle. It replaces free-running clock division with a same-clock enable, so the counter stays fully synchronous. It sits between the APB register file (config, clear and IRQ-clear strobes) and the interrupt output logic.

## Interface
- `DIV_W`, default 4: width of the prescale divisor field.
- `CNT_W`, default 32: width of the timer counter and the compare value.

- `clk`  in  1  system clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `timer_en`  in  1  level; 1 = counting requested.
- `cfg_wr`  in  1  one-cycle strobe; capture `div_en` and `div_val` into the shadow.
- `div_en`  in  1  1 = divide by `div_val+1`; 0 = tick every cycle.
- `div_val`  in  DIV_W  divisor minus one.
- `halt_req`  in  1  debug halt request (level).
- `cnt_clr`  in  1  one-cycle strobe; clear the counter and the prescaler.
- `cmp_val`  in  CNT_W  compare value.
- `irq_clr`  in  2  one-cycle strobes; [0] clears `ovf_irq`, [1] clears `cmp_irq`.
- `tick`  out  1  count-enable pulse.
- `cnt_val`  out  CNT_W  current count.
- `cfg_err`  out  1  one-cycle pulse: an illegal config write was dropped.
- `halt_ack`  out  1  1 while in HALTED.
- `ovf_irq`  out  1  sticky flag: counter wrapped.
- `cmp_irq`  out  1  sticky flag: counter reached `cmp_val`.

## Operation
- FSM states: IDLE, RUN, HALTED.
  - IDLE → RUN when `timer_en`=1.
  - RUN → IDLE when `timer_en`=0.
  - RUN → HALTED when `halt_req`=1 and `timer_en`=1.
  - HALTED → RUN when `halt_req`=0 and `timer_en`=1.
  - HALTED → IDLE when `timer_en`=0. This has priority over the halt transitions.
- Shadow registers `div_en_q` and `div_val_q`:
  - In IDLE, they load on `cfg_wr`.
  - In RUN or HALTED, `cfg_wr` with values different from the shadow is dropped and pulses `cfg_err` on the next cycle.
  - In RUN or HALTED, `cfg_wr` with identical values is a no-op with no error.
- Prescale counter `pcnt` (DIV_W bits):
  - Cleared to 0 on the IDLE→RUN transition, in IDLE, and on `cnt_clr`.
  - In RUN: when `pcnt`==`div_val_q`, it returns to 0; otherwise it increments.
  - Frozen in HALTED.
- `tick` = (state==RUN) && (`div_en_q`==0 || `pcnt`==`div_val_q`). It is a decode of registers only, with no input-to-output path.
- Counter update priority: `cnt_clr` first, then `tick` (increment by 1), then hold.
  - `cnt_clr` wins over a simultaneous `tick`.
  - The count is retained through IDLE and HALTED.
- Wrap-around: a `tick` at all-ones sets `cnt_val` to 0 and sets `ovf_irq`.
- Compare: a `tick` whose incremented value equals `cmp_val` sets `cmp_irq`. Reaching the value via `cnt_clr` with `cmp_val`=0 does not set it.
- IRQ flags: set and clear in the same cycle → set wins.

## Timing
- Reset values: state=IDLE; `pcnt`, `cnt_val`, `div_en_q`, `div_val_q` = 0; all outputs 0.
- Reset asserted mid-count returns everything to the reset values immediately (asynchronous).
- `timer_en` sampled high at edge E: RUN from cycle E+1. The first `tick` occurs in RUN cycle index `div_val_q` (0-based), or in the first RUN cycle when `div_en_q`=0.
- Steady-state `tick` period is `div_val_q`+1 cycles. Each `tick` is exactly one cycle high.
- `cnt_val` and the IRQ flags update at the edge that ends the `tick` cycle, so they are visible one cycle later.
- `cnt_clr` at edge E: `cnt_val`=0 and `pcnt`=0 from E+1. The next `tick` occurs `div_val_q`+1 cycles after E.
- `halt_req` at edge E: HALTED and `halt_ack`=1 from E+1, with no `tick`. On release, RUN resumes from the frozen `pcnt`.
- `cfg_err` is high for exactly one cycle, the cycle after the offending `cfg_wr`.

## Configuration
- `TIMER_HALT_EN` defined: HALTED state, `halt_req` and `halt_ack` behave as specified.
- `TIMER_HALT_EN` undefined:
  - No HALTED state; `halt_req` is ignored.
  - `halt_ack` is tied to 0.
  - The FSM has IDLE and RUN only.

## Test plan
- Reset, then `cfg_wr` with `div_en`=1, `div_val`=3, then `timer_en`=1 → `tick` every 4 cycles, first one in the 4th RUN cycle; after 5 ticks, `cnt_val`=5.
- `div_en`=0, `cmp_val`=10 → `tick` every cycle; `cmp_irq` rises the cycle after the 10th tick; `irq_clr[1]` asserted together with a compare hit → flag stays 1.
- Running, `cfg_wr` with `div_val`=7 (shadow holds 3) → `cfg_err` pulses once, period stays 4. Same write in IDLE → period becomes 8 once running again, with no error.
- `CNT_W`=8, run to 255, one more `tick` → `cnt_val`=0 and `ovf_irq`=1. `cnt_clr` coinciding with a `tick` → `cnt_val`=0, no increment.
- With `TIMER_HALT_EN` defined: `halt_req` while `pcnt`=2 (`div_val`=3) → `halt_ack`=1 next cycle and no ticks. On release, the next `tick` arrives 2 cycles later.
- Without `TIMER_HALT_EN`: `halt_req` pulses → ticks continue and `halt_ack` stays 0. `rst` asserted mid-count → all outputs 0 immediately.

Source files
------------

// File: rtl/timer_cnt_ctrl.sv
// Timer count-enable controller: prescale shadow, single-cycle tick, IDLE/RUN/HALTED sequencing.
// Define TIMER_HALT_EN to build the debug HALTED state; otherwise halt_req is ignored and halt_ack is 0.
module timer_cnt_ctrl #(
  parameter int DIV_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_en,
  input  logic             cfg_wr,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             halt_req,
  input  logic             cnt_clr,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic [1:0]       irq_clr,
  output logic             tick,
  output logic [CNT_W-1:0] cnt_val,
  output logic             cfg_err,
  output logic             halt_ack,
  output logic             ovf_irq,
  output logic             cmp_irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef TIMER_HALT_EN
    ST_HALTED = 2'd2,
`endif
    ST_RUN    = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_en_q, div_en_d;
  logic [DIV_W-1:0] div_val_q, div_val_d;
  logic             cfg_err_q, cfg_err_d;
  logic             ovf_q, ovf_d;
  logic             cmp_q, cmp_d;

  logic             st_idle;
  logic             st_run;
  logic             pcnt_wrap;
  logic             cfg_match;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_adv;
  logic             ovf_set;
  logic             cmp_set;

  assign st_idle   = (state_q == ST_IDLE);
  assign st_run    = (state_q == ST_RUN);
  assign pcnt_wrap = (pcnt_q == div_val_q);

  // Registered decode only, so no combinational path from any input to tick.
  assign tick = st_run && (!div_en_q || pcnt_wrap);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (timer_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!timer_en) state_d = ST_IDLE;
`ifdef TIMER_HALT_EN
        else if (halt_req) state_d = ST_HALTED;
`endif
      end
`ifdef TIMER_HALT_EN
      ST_HALTED: begin
        if (!timer_en) state_d = ST_IDLE;
        else if (!halt_req) state_d = ST_RUN;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef TIMER_HALT_EN
  assign halt_ack = (state_q == ST_HALTED);
`else
  logic halt_req_unused;
  assign halt_req_unused = halt_req;
  assign halt_ack        = 1'b0;
`endif

  // The shadow only changes while stopped; while counting, a differing write is reported and dropped.
  assign cfg_match = (div_en == div_en_q) && (div_val == div_val_q);

  always_comb begin
    div_en_d  = div_en_q;
    div_val_d = div_val_q;
    cfg_err_d = 1'b0;
    if (cfg_wr) begin
      if (st_idle) begin
        div_en_d  = div_en;
        div_val_d = div_val;
      end else if (!cfg_match) begin
        cfg_err_d = 1'b1;
      end
    end
  end

  // Prescaler holds its phase in HALTED so a resume continues the interrupted period.
  always_comb begin
    pcnt_d = pcnt_q;
    if (cnt_clr || st_idle) begin
      pcnt_d = '0;
    end else if (st_run) begin
      pcnt_d = pcnt_wrap ? '0 : pcnt_q + DIV_W'(1);
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign cnt_adv = tick && !cnt_clr;
  assign ovf_set = cnt_adv && (&cnt_q);
  assign cmp_set = cnt_adv && (cnt_inc == cmp_val);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_inc;
    end
  end

  // Flags are sticky; a new event in the clearing cycle keeps the flag up.
  always_comb begin
    ovf_d = ovf_set || (ovf_q && !irq_clr[0]);
    cmp_d = cmp_set || (cmp_q && !irq_clr[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pcnt_q    <= '0;
      cnt_q     <= '0;
      div_en_q  <= 1'b0;
      div_val_q <= '0;
      cfg_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      cmp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      cnt_q     <= cnt_d;
      div_en_q  <= div_en_d;
      div_val_q <= div_val_d;
      cfg_err_q <= cfg_err_d;
      ovf_q     <= ovf_d;
      cmp_q     <= cmp_d;
    end
  end

  assign cnt_val = cnt_q;
  assign cfg_err = cfg_err_q;
  assign ovf_irq = ovf_q;
  assign cmp_irq = cmp_q;

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Bench for timer_cnt_ctrl: directed steps plus random phase, every cycle compared with an integer reference model.
module tb_timer_cnt_ctrl;
  localparam int DIV_W = 4;
  localparam int CNT_W = 8;
  localparam int CMOD  = 256;
`ifdef TIMER_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic             clk, rst, timer_en, cfg_wr, div_en, halt_req, cnt_clr;
  logic [DIV_W-1:0] div_val;
  logic [CNT_W-1:0] cmp_val;
  logic [1:0]       irq_clr;
  logic             tick, cfg_err, halt_ack, ovf_irq, cmp_irq;
  logic [CNT_W-1:0] cnt_val;

  int n_assert = 0;
  int n_fail   = 0;
  // Model state: ms 0=idle 1=run 2=halted
  int ms, mpc, mcnt, mden, mdv, merr, movf, mcmp;
  int nt;

  timer_cnt_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .timer_en(timer_en), .cfg_wr(cfg_wr), .div_en(div_en),
    .div_val(div_val), .halt_req(halt_req), .cnt_clr(cnt_clr), .cmp_val(cmp_val),
    .irq_clr(irq_clr), .tick(tick), .cnt_val(cnt_val), .cfg_err(cfg_err),
    .halt_ack(halt_ack), .ovf_irq(ovf_irq), .cmp_irq(cmp_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; mpc = 0; mcnt = 0; mden = 0; mdv = 0; merr = 0; movf = 0; mcmp = 0;
  endtask

  // Compare current outputs, advance the model with current inputs, then step one clock.
  task automatic cyc();
    int ns, npc, ncnt, nden, ndv, nerr, etick, sovf, scmp;
    etick = (ms == 1 && (mden == 0 || mpc == mdv)) ? 1 : 0;
    chk("tick", tick, etick);
    chk("cnt_val", cnt_val, mcnt);
    chk("cfg_err", cfg_err, merr);
    chk("halt_ack", halt_ack, (ms == 2) ? 1 : 0);
    chk("ovf_irq", ovf_irq, movf);
    chk("cmp_irq", cmp_irq, mcmp);

    case (ms)
      0:       ns = timer_en ? 1 : 0;
      1:       ns = !timer_en ? 0 : ((HALT && halt_req) ? 2 : 1);
      default: ns = !timer_en ? 0 : (halt_req ? 2 : 1);
    endcase

    nden = mden; ndv = mdv; nerr = 0;
    if (cfg_wr) begin
      if (ms == 0) begin
        nden = int'(div_en); ndv = int'(div_val);
      end else if (int'(div_en) != mden || int'(div_val) != mdv) begin
        nerr = 1;
      end
    end

    if (cnt_clr || ms == 0) npc = 0;
    else if (ms == 1)       npc = (mpc + 1) % (mdv + 1);
    else                    npc = mpc;

    sovf = 0; scmp = 0;
    if (cnt_clr) ncnt = 0;
    else if (etick == 1) begin
      ncnt = (mcnt + 1) % CMOD;
      sovf = (mcnt == CMOD - 1) ? 1 : 0;
      scmp = (ncnt == int'(cmp_val)) ? 1 : 0;
    end else ncnt = mcnt;

    movf = (sovf == 1 || (movf == 1 && !irq_clr[0])) ? 1 : 0;
    mcmp = (scmp == 1 || (mcmp == 1 && !irq_clr[1])) ? 1 : 0;
    ms = ns; mpc = npc; mcnt = ncnt; mden = nden; mdv = ndv; merr = nerr;

    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; timer_en = 0; cfg_wr = 0; div_en = 0; div_val = '0; halt_req = 0;
    cnt_clr = 0; cmp_val = '0; irq_clr = '0;
    @(posedge clk); #1;
    chk("rst_tick", tick, 0);
    chk("rst_cnt", cnt_val, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_ack", halt_ack, 0);
    chk("rst_ovf", ovf_irq, 0);
    chk("rst_cmp", cmp_irq, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    model_reset();

    // Divide by 4: first tick in RUN cycle 3, five ticks after 20 RUN cycles
    cfg_wr = 1; div_en = 1; div_val = 4'd3; cyc(); cfg_wr = 0;
    timer_en = 1;
    repeat (4) cyc();
    chk("first_tick", tick, 1);
    repeat (17) cyc();
    chk("five_ticks", cnt_val, 5);

    // Differing write while running is dropped with a one-cycle error
    cfg_wr = 1; div_val = 4'd7; cyc(); cfg_wr = 0;
    chk("cfg_err_pulse", cfg_err, 1);
    cyc();
    chk("cfg_err_once", cfg_err, 0);
    repeat (8) cyc();
    cfg_wr = 1; div_val = 4'd3; cyc(); cfg_wr = 0;
    chk("same_cfg_no_err", cfg_err, 0);

    // Same write in IDLE takes effect: period 8
    timer_en = 0; cyc();
    cfg_wr = 1; div_val = 4'd7; cyc(); cfg_wr = 0;
    chk("idle_cfg_no_err", cfg_err, 0);
    timer_en = 1; nt = 0;
    for (int i = 0; i < 17; i++) begin
      if (tick) nt++;
      cyc();
    end
    chk("div8_ticks", nt, 2);

    // No prescale, compare at 10 with simultaneous clear
    timer_en = 0; cyc();
    cnt_clr = 1; cyc(); cnt_clr = 0;
    cfg_wr = 1; div_en = 0; div_val = '0; cyc(); cfg_wr = 0;
    cmp_val = 8'd10; timer_en = 1; cyc();
    repeat (9) cyc();
    chk("pre_cmp", cmp_irq, 0);
    irq_clr = 2'b10; cyc(); irq_clr = '0;
    chk("cmp_set_wins", cmp_irq, 1);
    chk("cmp_cnt", cnt_val, 10);
    irq_clr = 2'b10; cyc(); irq_clr = '0;
    chk("cmp_cleared", cmp_irq, 0);

    // Wrap from all-ones
    for (int k = 0; k < 400 && mcnt != CMOD - 1; k++) cyc();
    chk("pre_wrap", cnt_val, 255);
    cyc();
    chk("wrap_cnt", cnt_val, 0);
    chk("wrap_ovf", ovf_irq, 1);
    repeat (3) cyc();
    cmp_val = '0; cnt_clr = 1;
    chk("clr_with_tick_pre", tick, 1);
    cyc(); cnt_clr = 0;
    chk("clr_beats_tick", cnt_val, 0);
    chk("clr_no_cmp", cmp_irq, 0);
    cmp_val = 8'd10;

`ifdef TIMER_HALT_EN
    timer_en = 0; cyc();
    cfg_wr = 1; div_en = 1; div_val = 4'd3; cyc(); cfg_wr = 0;
    timer_en = 1; cyc();
    cyc();
    halt_req = 1; cyc();
    chk("halt_ack", halt_ack, 1);
    chk("halt_no_tick", tick, 0);
    nt = 0;
    for (int i = 0; i < 3; i++) begin
      if (tick) nt++;
      cyc();
    end
    chk("halted_ticks", nt, 0);
    halt_req = 0; cyc();
    chk("resume_wait", tick, 0);
    cyc();
    chk("resume_tick", tick, 1);
`else
    halt_req = 1; nt = 0;
    for (int i = 0; i < 4; i++) begin
      if (tick) nt++;
      cyc();
    end
    halt_req = 0;
    chk("halt_ignored_ticks", nt, 4);
    chk("halt_ack_zero", halt_ack, 0);
`endif

    // Random phase
    for (int i = 0; i < 400; i++) begin
      timer_en = ($urandom_range(0, 9) != 0);
      cfg_wr   = ($urandom_range(0, 7) == 0);
      div_en   = 1'($urandom_range(0, 1));
      div_val  = DIV_W'($urandom_range(0, 3));
      halt_req = ($urandom_range(0, 5) == 0);
      cnt_clr  = ($urandom_range(0, 19) == 0);
      irq_clr  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      if ($urandom_range(0, 15) == 0) cmp_val = CNT_W'($urandom_range(0, 40));
      cyc();
    end

    // Asynchronous reset mid-count
    timer_en = 1; cfg_wr = 0; halt_req = 0; cnt_clr = 0; irq_clr = '0;
    for (int k = 0; k < 100 && mcnt == 0; k++) cyc();
    chk("pre_rst_cnt_nonzero", (cnt_val != 0) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_cnt", cnt_val, 0);
    chk("arst_err", cfg_err, 0);
    chk("arst_ack", halt_ack, 0);
    chk("arst_ovf", ovf_irq, 0);
    chk("arst_cmp", cmp_irq, 0);
    #2 rst = 1'b0; timer_en = 0;
    @(posedge clk); #1;
    model_reset();
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
